phase_ctrl: RTL and testbench
=============================

PHASE_CTRL -- requirements
Module: phase_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1024: max cycles a non-IDLE phase may wait for its done before abort; legal range 2..65535.
REQ-002 clk  input  1  sole clock; all logic on rising edge; one clock, reset is synchronous and active-high.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 state  input  STATE_LEN  current phase from the sequencer (IDLE, RECV, EMB, MIX1, MIX2, MIX3, DENS, COMP, SEND).
REQ-005 go  input  1  host request to leave IDLE; level, sampled only in IDLE.
REQ-006 recv_done, emb_done, mix_done, dens_done, comp_done, send_done  input  1 each  engine completion pulses.
REQ-007 recv_start, emb_start, mix_start, dens_start, comp_start, send_start  output  1 each  one-cycle engine start pulses.
REQ-008 mix_layer  output  2  mixer layer index: 0/1/2 for MIX1/MIX2/MIX3, 0 otherwise.
REQ-009 run  output  1  one-cycle advance pulse to the sequencer.
REQ-010 set_o  output  1  one-cycle force-load pulse to the sequencer.
REQ-011 d_o  output  STATE_LEN  force-load value; constant IDLE.
REQ-012 err  output  1  sticky fault flag.
REQ-013 busy  output  1  high whenever the internal FSM is not in HOLD or idle-wait.

Function
REQ-014 Internal FSM states: ARM, START, WAIT, RUN, HOLD, ABORT.
REQ-015 ARM: latch state into cur; if cur==IDLE go WAIT, else if cur is a legal phase go START, else go ABORT.
REQ-016 START: assert exactly the start output mapped to cur for one cycle (MIX1/2/3 all map to mix_start); clear timer; go WAIT.
REQ-017 WAIT, cur==IDLE: no timeout; go==1 -> RUN.
REQ-018 WAIT, cur!=IDLE: matching done==1 -> RUN; else timer increments; timer reaching TIMEOUT-1 without done -> ABORT.
REQ-019 Done and timeout in the same cycle: done wins, no abort.
REQ-020 Done pulses for non-current phases are ignored in all states.
REQ-021 RUN: run=1 for exactly one cycle; go HOLD.
REQ-022 HOLD: remain until state!=cur, then ARM; run is never reissued while state==cur.
REQ-023 In START or WAIT, state!=cur (external load) -> ARM next cycle, no run issued, timer cleared.
REQ-024 ABORT: set_o=1 one cycle with d_o=IDLE, err set; go HOLD.
REQ-025 err stays 1 until rst; operation continues normally after abort.
REQ-026 Latency: state change -> start pulse 2 cycles later (HOLD->ARM->START); done -> run 1 cycle later.
REQ-027 mix_layer is registered from cur and stable from START through RUN.
REQ-028 run and set_o are never asserted in the same cycle.

Reset
REQ-029 rst: FSM=ARM, cur=IDLE, timer=0, err=0, run=0, set_o=0, all *_start=0, mix_layer=0, busy=0.
REQ-030 rst asserted mid-phase aborts it with no run or start pulse on the following cycle.

Structure
REQ-031 Phase codes and STATE_LEN come from the shared consts.vh; FSM state codes and TIMEOUT width ($clog2) are local.
REQ-032 Timeout counter is one sub-module, phase_timer (clear, enable, expire at TIMEOUT-1); all else is flat.

Verification
REQ-033 Reset, state=IDLE, go=1 at cycle 5 -> run pulse at cycle 6, no start pulses, err=0.
REQ-034 state steps RECV..SEND, each done 3 cycles after start -> one matching start and one run per phase, mix_layer 0,1,2 on MIX1..3.
REQ-035 TIMEOUT=8, state=EMB, emb_done never -> set_o pulse with d_o=IDLE 8 cycles after emb_start, err=1 and held.
REQ-036 TIMEOUT=8, emb_done on the expiry cycle -> run pulse, no set_o, err=0.
REQ-037 In WAIT on DENS, state forced to COMP -> no run, comp_start 2 cycles after the change; stray dens_done ignored.
REQ-038 Illegal state code after reset -> set_o and err within 2 cycles; rst mid-WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/phase_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : phase_ctrl_pkg
//  Purpose  : Phase codes shared between the sequencer and phase_ctrl,
//             plus small decode helpers.
//  Revision : 1.0  initial release
// ============================================================================
package phase_ctrl_pkg;

  localparam int STATE_LEN = 4;

  typedef enum logic [STATE_LEN-1:0] {
    PH_IDLE = 4'd0,
    PH_RECV = 4'd1,
    PH_EMB  = 4'd2,
    PH_MIX1 = 4'd3,
    PH_MIX2 = 4'd4,
    PH_MIX3 = 4'd5,
    PH_DENS = 4'd6,
    PH_COMP = 4'd7,
    PH_SEND = 4'd8
  } phase_e;

  // Codes above SEND are unused by the sequencer and treated as faults.
  function automatic logic phase_legal(input logic [STATE_LEN-1:0] s);
    return (s <= 4'(PH_SEND));
  endfunction

  // Mixer layer index for the three MIX phases, zero elsewhere.
  function automatic logic [1:0] phase_layer(input logic [STATE_LEN-1:0] s);
    case (s)
      4'(PH_MIX2): return 2'd1;
      4'(PH_MIX3): return 2'd2;
      default:     return 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : phase_ctrl_if
//  Purpose  : Sequencer / engine handshake bundle around phase_ctrl.
//             master = phase_ctrl side, slave = sequencer + engines side.
//  Revision : 1.0  initial release
// ============================================================================
interface phase_ctrl_if;
  import phase_ctrl_pkg::*;

  logic [STATE_LEN-1:0] state;
  logic                 go;
  logic                 recv_done, emb_done, mix_done, dens_done, comp_done, send_done;
  logic                 recv_start, emb_start, mix_start, dens_start, comp_start, send_start;
  logic [1:0]           mix_layer;
  logic                 run;
  logic                 set_o;
  logic [STATE_LEN-1:0] d_o;
  logic                 err;
  logic                 busy;

  modport master (
    input  state, go,
    input  recv_done, emb_done, mix_done, dens_done, comp_done, send_done,
    output recv_start, emb_start, mix_start, dens_start, comp_start, send_start,
    output mix_layer, run, set_o, d_o, err, busy
  );

  modport slave (
    output state, go,
    output recv_done, emb_done, mix_done, dens_done, comp_done, send_done,
    input  recv_start, emb_start, mix_start, dens_start, comp_start, send_start,
    input  mix_layer, run, set_o, d_o, err, busy
  );

endinterface
`default_nettype wire

// File: rtl/phase_ctrl_timer.sv
`default_nettype none
// ============================================================================
//  Module   : phase_timer
//  Purpose  : Per-phase wait counter. expire_o flags the cycle whose
//             increment would bring the count to TIMEOUT-1.
//  Revision : 1.0  initial release
// ============================================================================
module phase_timer #(
  parameter int TIMEOUT = 1024
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clear_i,
  input  wire logic enable_i,
  output logic      expire_o
);

  localparam int c_TW = $clog2(TIMEOUT);

  logic [c_TW-1:0] count_q;

  // Count waiting cycles; cleared whenever the controller is not waiting.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expire_o = (count_q == c_TW'(TIMEOUT - 2));

endmodule
`default_nettype wire

// File: rtl/phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : phase_ctrl
//  Purpose  : Per-phase controller: starts the engine for the current
//             sequencer phase, waits for its done (with timeout), then
//             pulses run to advance, or forces the sequencer back to IDLE.
//  Revision : 1.0  initial release
// ============================================================================
module phase_ctrl
  import phase_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  wire logic    clk,
  input  wire logic    rst,
  phase_ctrl_if.master bus
);

  localparam logic [2:0] c_ARM   = 3'd0;
  localparam logic [2:0] c_START = 3'd1;
  localparam logic [2:0] c_WAIT  = 3'd2;
  localparam logic [2:0] c_RUN   = 3'd3;
  localparam logic [2:0] c_HOLD  = 3'd4;
  localparam logic [2:0] c_ABORT = 3'd5;

  logic [2:0]           fsm_q, fsm_d;
  logic [STATE_LEN-1:0] cur_q, cur_d;
  logic [5:0]           start_q, start_d;   // {send,comp,dens,mix,emb,recv}
  logic                 run_q, run_d;
  logic                 set_q, set_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic [1:0]           layer_q, layer_d;

  logic w_done_match;
  logic w_moved;
  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_expire;

  // Only the done belonging to the latched phase is honoured.
  always_comb begin
    w_done_match = 1'b0;
    case (cur_q)
      4'(PH_RECV): w_done_match = bus.recv_done;
      4'(PH_EMB):  w_done_match = bus.emb_done;
      4'(PH_MIX1),
      4'(PH_MIX2),
      4'(PH_MIX3): w_done_match = bus.mix_done;
      4'(PH_DENS): w_done_match = bus.dens_done;
      4'(PH_COMP): w_done_match = bus.comp_done;
      4'(PH_SEND): w_done_match = bus.send_done;
      default:     w_done_match = 1'b0;
    endcase
  end

  assign w_moved   = (bus.state != cur_q);
  assign w_tmr_clr = (fsm_q != c_WAIT);
  assign w_tmr_en  = (fsm_q == c_WAIT) && (cur_q != 4'(PH_IDLE)) && !w_done_match;

  phase_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (w_tmr_clr),
    .enable_i (w_tmr_en),
    .expire_o (w_expire)
  );

  // State, latched phase and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= c_ARM;
      cur_q   <= 4'(PH_IDLE);
      start_q <= '0;
      run_q   <= 1'b0;
      set_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      layer_q <= 2'd0;
    end else begin
      fsm_q   <= fsm_d;
      cur_q   <= cur_d;
      start_q <= start_d;
      run_q   <= run_d;
      set_q   <= set_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      layer_q <= layer_d;
    end
  end

  // Next-state: an external phase change always wins over done/timeout.
  always_comb begin
    fsm_d = fsm_q;
    cur_d = cur_q;
    case (fsm_q)
      c_ARM: begin
        cur_d = bus.state;
        if (bus.state == 4'(PH_IDLE))      fsm_d = c_WAIT;
        else if (phase_legal(bus.state))   fsm_d = c_START;
        else                               fsm_d = c_ABORT;
      end
      c_START: fsm_d = w_moved ? c_ARM : c_WAIT;
      c_WAIT: begin
        if (w_moved)                        fsm_d = c_ARM;
        else if (cur_q == 4'(PH_IDLE)) begin
          if (bus.go)                       fsm_d = c_RUN;
        end
        else if (w_done_match)              fsm_d = c_RUN;
        else if (w_expire)                  fsm_d = c_ABORT;
      end
      c_RUN:   fsm_d = c_HOLD;
      c_ABORT: fsm_d = c_HOLD;
      c_HOLD:  if (w_moved) fsm_d = c_ARM;
      default: fsm_d = c_ARM;
    endcase
  end

  // Output decode from the next state so every output is a clean register.
  always_comb begin
    start_d = '0;
    if (fsm_d == c_START) begin
      case (cur_d)
        4'(PH_RECV): start_d[0] = 1'b1;
        4'(PH_EMB):  start_d[1] = 1'b1;
        4'(PH_MIX1),
        4'(PH_MIX2),
        4'(PH_MIX3): start_d[2] = 1'b1;
        4'(PH_DENS): start_d[3] = 1'b1;
        4'(PH_COMP): start_d[4] = 1'b1;
        4'(PH_SEND): start_d[5] = 1'b1;
        default:     start_d    = '0;
      endcase
    end
    run_d   = (fsm_d == c_RUN);
    set_d   = (fsm_d == c_ABORT);
    err_d   = err_q | set_d;
    busy_d  = !((fsm_d == c_HOLD) || ((fsm_d == c_WAIT) && (cur_d == 4'(PH_IDLE))));
    layer_d = phase_layer(cur_d);
  end

  assign bus.recv_start = start_q[0];
  assign bus.emb_start  = start_q[1];
  assign bus.mix_start  = start_q[2];
  assign bus.dens_start = start_q[3];
  assign bus.comp_start = start_q[4];
  assign bus.send_start = start_q[5];
  assign bus.mix_layer  = layer_q;
  assign bus.run        = run_q;
  assign bus.set_o      = set_q;
  assign bus.d_o        = 4'(PH_IDLE);
  assign bus.err        = err_q;
  assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phase_ctrl
//  Purpose  : Directed self-checking bench for phase_ctrl (TIMEOUT = 8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_phase_ctrl;
  import phase_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  phase_ctrl_if bus ();

  phase_ctrl #(
    .TIMEOUT (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] starts();
    return {bus.send_start, bus.comp_start, bus.dens_start,
            bus.mix_start, bus.emb_start, bus.recv_start};
  endfunction

  task automatic set_done(input logic [5:0] v);
    bus.recv_done = v[0];
    bus.emb_done  = v[1];
    bus.mix_done  = v[2];
    bus.dens_done = v[3];
    bus.comp_done = v[4];
    bus.send_done = v[5];
  endtask

  // One full phase from HOLD: change, ARM, START, stray done, matching done, RUN, HOLD.
  task automatic phase_step(input logic [3:0] ph, input logic [5:0] sv, input logic [1:0] layer);
    bus.state = ph;
    step;                                            // ARM
    check("arm_starts", 32'(starts()), 32'h0);
    check("arm_busy", 32'(bus.busy), 32'h1);
    step;                                            // START
    check("start_vec", 32'(starts()), 32'(sv));
    check("start_layer", 32'(bus.mix_layer), 32'(layer));
    set_done(~sv);                                   // stray dones, other phases
    step;                                            // WAIT +1
    set_done(6'h0);
    check("wait_starts", 32'(starts()), 32'h0);
    step;                                            // WAIT +2
    check("stray_run", 32'(bus.run), 32'h0);
    step;                                            // WAIT +3
    set_done(sv);
    step;                                            // RUN
    set_done(6'h0);
    check("done_run", 32'(bus.run), 32'h1);
    check("run_layer", 32'(bus.mix_layer), 32'(layer));
    check("run_set", 32'(bus.set_o), 32'h0);
    step;                                            // HOLD
    check("hold_run", 32'(bus.run), 32'h0);
    check("hold_busy", 32'(bus.busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    bus.state = 4'(PH_IDLE);
    bus.go    = 1'b0;
    set_done(6'h0);
    step;
    step;
    check("rst_starts", 32'(starts()), 32'h0);
    check("rst_run", 32'(bus.run), 32'h0);
    check("rst_set", 32'(bus.set_o), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_layer", 32'(bus.mix_layer), 32'h0);
    check("d_o", 32'(bus.d_o), 32'(PH_IDLE));

    // Idle: go -> run one cycle later, no starts; no re-run while held in IDLE.
    rst = 1'b0;
    step;
    check("idle_busy", 32'(bus.busy), 32'h0);
    step;
    step;
    bus.go = 1'b1;
    step;
    check("idle_run", 32'(bus.run), 32'h1);
    check("idle_starts", 32'(starts()), 32'h0);
    step;
    check("idle_hold_run", 32'(bus.run), 32'h0);
    step;
    check("idle_hold_run2", 32'(bus.run), 32'h0);
    bus.go = 1'b0;
    check("idle_err", 32'(bus.err), 32'h0);

    // Full phase walk.
    phase_step(4'(PH_RECV), 6'b000001, 2'd0);
    phase_step(4'(PH_EMB),  6'b000010, 2'd0);
    phase_step(4'(PH_MIX1), 6'b000100, 2'd0);
    phase_step(4'(PH_MIX2), 6'b000100, 2'd1);
    phase_step(4'(PH_MIX3), 6'b000100, 2'd2);
    phase_step(4'(PH_DENS), 6'b001000, 2'd0);
    phase_step(4'(PH_COMP), 6'b010000, 2'd0);
    phase_step(4'(PH_SEND), 6'b100000, 2'd0);
    bus.state = 4'(PH_IDLE);
    step;
    step;
    check("seq_idle_busy", 32'(bus.busy), 32'h0);
    check("seq_err", 32'(bus.err), 32'h0);

    // Timeout: no emb_done -> set_o 8 cycles after emb_start.
    bus.state = 4'(PH_EMB);
    step;
    step;
    check("to_start", 32'(starts()), 32'b000010);
    for (int i = 1; i <= 7; i++) begin
      step;
      check("to_early_set", 32'(bus.set_o), 32'h0);
    end
    step;
    check("to_set", 32'(bus.set_o), 32'h1);
    check("to_d_o", 32'(bus.d_o), 32'(PH_IDLE));
    check("to_err", 32'(bus.err), 32'h1);
    check("to_run", 32'(bus.run), 32'h0);
    step;
    check("to_set_clr", 32'(bus.set_o), 32'h0);
    bus.state = 4'(PH_IDLE);
    step;
    step;
    check("to_err_held", 32'(bus.err), 32'h1);

    // Done on the expiry cycle wins.
    rst       = 1'b1;
    bus.state = 4'(PH_EMB);
    step;
    check("rst_err_clr", 32'(bus.err), 32'h0);
    rst = 1'b0;
    step;
    check("ex_start", 32'(starts()), 32'b000010);
    for (int i = 1; i <= 7; i++) step;
    bus.emb_done = 1'b1;
    step;
    bus.emb_done = 1'b0;
    check("ex_run", 32'(bus.run), 32'h1);
    check("ex_set", 32'(bus.set_o), 32'h0);
    check("ex_err", 32'(bus.err), 32'h0);
    step;

    // External load during WAIT on DENS.
    bus.state = 4'(PH_DENS);
    step;
    step;
    check("ld_dens_start", 32'(starts()), 32'b001000);
    step;
    bus.state     = 4'(PH_COMP);
    bus.dens_done = 1'b1;
    step;
    bus.dens_done = 1'b0;
    check("ld_no_run", 32'(bus.run), 32'h0);
    check("ld_no_start", 32'(starts()), 32'h0);
    step;
    check("ld_comp_start", 32'(starts()), 32'b010000);
    step;
    bus.dens_done = 1'b1;
    step;
    bus.dens_done = 1'b0;
    check("ld_stray_dens", 32'(bus.run), 32'h0);
    bus.comp_done = 1'b1;
    step;
    bus.comp_done = 1'b0;
    check("ld_comp_run", 32'(bus.run), 32'h1);
    step;

    // Illegal phase code straight after reset.
    rst       = 1'b1;
    bus.state = 4'hB;
    step;
    step;
    rst = 1'b0;
    step;
    check("ill_set", 32'(bus.set_o), 32'h1);
    check("ill_err", 32'(bus.err), 32'h1);
    check("ill_starts", 32'(starts()), 32'h0);
    bus.state = 4'(PH_IDLE);
    step;
    step;
    step;

    // Reset in the middle of WAIT clears everything next cycle.
    bus.state = 4'(PH_RECV);
    step;
    step;
    check("mr_start", 32'(starts()), 32'b000001);
    step;
    check("mr_busy", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    step;
    check("mr_starts", 32'(starts()), 32'h0);
    check("mr_run", 32'(bus.run), 32'h0);
    check("mr_set", 32'(bus.set_o), 32'h0);
    check("mr_err", 32'(bus.err), 32'h0);
    check("mr_busy0", 32'(bus.busy), 32'h0);
    check("mr_layer", 32'(bus.mix_layer), 32'h0);
    rst       = 1'b0;
    bus.state = 4'(PH_IDLE);
    step;
    step;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
